// File: rtl/drawcon_pkg.sv
// Shared constants and helpers for the block-and-wall drawing controller.
// Colours are stored as 32-bit channels and truncated to COLOR_W where used.
package drawcon_pkg;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
    } rgb_t;

    localparam rgb_t COL_WHITE = '{r: 32'hFFFF_FFFF, g: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF};
    localparam rgb_t COL_RED   = '{r: 32'hFFFF_FFFF, g: 32'd0, b: 32'd0};
    localparam rgb_t COL_BLOCK = '{r: 32'd13, g: 32'd7, b: 32'd8};

    // Widest flattened per-wall bus the slicing helper accepts.
    localparam int BUS_MAX = 512;

    function automatic logic [31:0] wall_field(input logic [BUS_MAX-1:0] bus,
                                               input int idx, input int w);
        return 32'(bus >> (idx * w)) & 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/drawcon_multi_if.sv
// Pixel stream between the VGA timing generator and the colour controller.
interface drawcon_multi_if #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 4
);
    // No backpressure: every coordinate presented with pix_valid_in=1 is taken in
    // that cycle and its colour leaves with pix_valid_out=1 exactly two cycles later.
    logic [COORD_W-1:0] draw_x;
    logic [COORD_W-1:0] draw_y;
    logic               pix_valid_in;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               pix_valid_out;

    modport master (output draw_x, draw_y, pix_valid_in,
                    input  r, g, b, pix_valid_out);
    modport slave  (input  draw_x, draw_y, pix_valid_in,
                    output r, g, b, pix_valid_out);
endinterface

// File: rtl/drawcon_wall_unit.sv
// One wall channel: frame snapshot, pixel hit, collision and pass tracking.
module drawcon_wall_unit
    import drawcon_pkg::*;
#(
    parameter int COORD_W  = 11,
    parameter int BLK_SIZE = 32,
    parameter int WALL_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               eval,
    input  logic               restart,
    input  logic               lose,
    input  logic [COORD_W-1:0] wall_x_in,
    input  logic [COORD_W-1:0] gap_y_in,
    input  logic [COORD_W-1:0] gap_size_in,
    input  logic               wall_en_in,
    input  logic [COORD_W-1:0] blk_x,
    input  logic [COORD_W-1:0] blk_y,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               on_wall,
    output logic               collide,
    output logic               pass_pulse
);
    localparam int AW = COORD_W + 2;

    logic [COORD_W-1:0] wx_q, gy_q, gs_q;
    logic               en_q;
    logic               pass_flag;
    logic [AW-1:0]      wx, gy, gs, bx, by, dx, dy, gap_end;
    logic               pass_cond, recycle;

    // Everything is widened so sums never wrap and no subtraction is needed.
    assign wx      = AW'(wx_q);
    assign gy      = AW'(gy_q);
    assign gs      = AW'(gs_q);
    assign bx      = AW'(blk_x);
    assign by      = AW'(blk_y);
    assign dx      = AW'(draw_x);
    assign dy      = AW'(draw_y);
    assign gap_end = gy + gs;

    assign on_wall = en_q && (dx > wx) && (dx < wx + AW'(WALL_W))
                     && ((dy < gy) || (dy > gap_end));

    assign collide = en_q && (bx + AW'(BLK_SIZE - 1) > wx) && (bx < wx + AW'(WALL_W + 1))
                     && ((by < gy) || (by + AW'(BLK_SIZE) > gap_end));

    assign pass_cond  = en_q && !pass_flag && !lose && (bx > wx + AW'(WALL_W));
    assign recycle    = !en_q || (bx + AW'(BLK_SIZE) <= wx);
    assign pass_pulse = eval && pass_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wx_q      <= '0;
            gy_q      <= '0;
            gs_q      <= '0;
            en_q      <= 1'b0;
            pass_flag <= 1'b0;
        end else begin
            if (frame_start) begin
                wx_q <= wall_x_in;
                gy_q <= gap_y_in;
                gs_q <= gap_size_in;
                en_q <= wall_en_in;
            end
            if (restart) begin
                pass_flag <= 1'b0;
            end else if (eval) begin
                if (pass_cond) pass_flag <= 1'b1;
                else if (recycle) pass_flag <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/drawcon_multi.sv
// Pixel colour and collision controller for the block-and-wall game:
// per-frame snapshots, sticky lose flag, saturating pass score, 2-stage colour pipe.
module drawcon_multi
    import drawcon_pkg::*;
#(
    parameter int NUM_WALLS = 4,
    parameter int COORD_W   = 11,
    parameter int COLOR_W   = 4,
    parameter int BLK_SIZE  = 32,
    parameter int WALL_W    = 10,
    parameter int FIELD_X0  = 9,
    parameter int FIELD_X1  = 1429,
    parameter int FIELD_Y0  = 9,
    parameter int FIELD_Y1  = 889,
    parameter int FLASH_BIT = 4,
    parameter int SCORE_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic                         restart,
    input  logic [3*COLOR_W-1:0]         sw,
    input  logic [COORD_W-1:0]           blkpos_x,
    input  logic [COORD_W-1:0]           blkpos_y,
    input  logic [NUM_WALLS*COORD_W-1:0] wall_x,
    input  logic [NUM_WALLS*COORD_W-1:0] gap_y,
    input  logic [NUM_WALLS*COORD_W-1:0] gap_size,
    input  logic [NUM_WALLS-1:0]         wall_en,
    drawcon_multi_if.slave               pix,
    output logic                         lose,
    output logic [NUM_WALLS-1:0]         hit_wall,
    output logic [SCORE_W-1:0]           score
);
    localparam int AW    = COORD_W + 2;
    localparam int SUM_W = $clog2(NUM_WALLS + 1);
    localparam int SS_W  = SCORE_W + SUM_W;
    localparam logic [3*COLOR_W-1:0] RGB_WHITE =
        {COLOR_W'(COL_WHITE.r), COLOR_W'(COL_WHITE.g), COLOR_W'(COL_WHITE.b)};
    localparam logic [3*COLOR_W-1:0] RGB_RED =
        {COLOR_W'(COL_RED.r), COLOR_W'(COL_RED.g), COLOR_W'(COL_RED.b)};
    localparam logic [3*COLOR_W-1:0] RGB_BLOCK =
        {COLOR_W'(COL_BLOCK.r), COLOR_W'(COL_BLOCK.g), COLOR_W'(COL_BLOCK.b)};

    logic [COORD_W-1:0]   blk_x_q, blk_y_q;
    logic                 eval_q;
    logic [7:0]           frame_cnt;
    logic [NUM_WALLS-1:0] on_wall, collide, pass_pulse;
    logic [SUM_W-1:0]     pass_cnt;
    logic [SS_W-1:0]      score_sum;
    logic [SCORE_W-1:0]   score_next;
    logic [AW-1:0]        dx, dy, bx, by;
    logic                 in_field, on_blk;
    logic                 v1, in_field1, on_blk1, on_wall1, v2;
    logic [3*COLOR_W-1:0] rgb_q;

    for (genvar i = 0; i < NUM_WALLS; i++) begin : gen_wall
        drawcon_wall_unit #(
            .COORD_W (COORD_W),
            .BLK_SIZE(BLK_SIZE),
            .WALL_W  (WALL_W)
        ) u_wall (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_start(frame_start),
            .eval       (eval_q),
            .restart    (restart),
            .lose       (lose),
            .wall_x_in  (COORD_W'(wall_field(BUS_MAX'(wall_x), i, COORD_W))),
            .gap_y_in   (COORD_W'(wall_field(BUS_MAX'(gap_y), i, COORD_W))),
            .gap_size_in(COORD_W'(wall_field(BUS_MAX'(gap_size), i, COORD_W))),
            .wall_en_in (wall_en[i]),
            .blk_x      (blk_x_q),
            .blk_y      (blk_y_q),
            .draw_x     (pix.draw_x),
            .draw_y     (pix.draw_y),
            .on_wall    (on_wall[i]),
            .collide    (collide[i]),
            .pass_pulse (pass_pulse[i])
        );
    end

    always_comb begin
        pass_cnt = '0;
        for (int k = 0; k < NUM_WALLS; k++) pass_cnt = pass_cnt + SUM_W'(pass_pulse[k]);
    end

    assign score_sum  = SS_W'(score) + SS_W'(pass_cnt);
    assign score_next = (score_sum > SS_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}}
                                                             : score_sum[SCORE_W-1:0];

    // Game state: snapshot on frame_start, evaluate one cycle later; restart wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_x_q   <= '0;
            blk_y_q   <= '0;
            eval_q    <= 1'b0;
            frame_cnt <= '0;
            lose      <= 1'b0;
            hit_wall  <= '0;
            score     <= '0;
        end else begin
            eval_q <= frame_start;
            if (frame_start) begin
                blk_x_q   <= blkpos_x;
                blk_y_q   <= blkpos_y;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (restart) begin
                lose     <= 1'b0;
                hit_wall <= '0;
                score    <= '0;
            end else if (eval_q) begin
                hit_wall <= collide;
                if (|collide) lose <= 1'b1;
                score <= score_next;
            end
        end
    end

    assign dx       = AW'(pix.draw_x);
    assign dy       = AW'(pix.draw_y);
    assign bx       = AW'(blk_x_q);
    assign by       = AW'(blk_y_q);
    assign in_field = (dx > AW'(FIELD_X0)) && (dx < AW'(FIELD_X1))
                      && (dy > AW'(FIELD_Y0)) && (dy < AW'(FIELD_Y1));
    assign on_blk   = (dx > bx) && (dx < bx + AW'(BLK_SIZE))
                      && (dy > by) && (dy < by + AW'(BLK_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            in_field1 <= 1'b0;
            on_blk1   <= 1'b0;
            on_wall1  <= 1'b0;
            v2        <= 1'b0;
            rgb_q     <= '0;
        end else begin
            v1        <= pix.pix_valid_in;
            in_field1 <= in_field;
            on_blk1   <= on_blk;
            on_wall1  <= |on_wall;
            v2        <= v1;
            if (!v1) rgb_q <= '0;
            else if (lose && !frame_cnt[FLASH_BIT]) rgb_q <= RGB_RED;
            else if (!in_field1) rgb_q <= RGB_WHITE;
            else if (on_blk1) rgb_q <= RGB_BLOCK;
            else if (on_wall1) rgb_q <= RGB_RED;
            else rgb_q <= {sw[COLOR_W-1:0], sw[2*COLOR_W-1:COLOR_W], sw[3*COLOR_W-1:2*COLOR_W]};
        end
    end

    assign pix.r             = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign pix.g             = rgb_q[2*COLOR_W-1:COLOR_W];
    assign pix.b             = rgb_q[COLOR_W-1:0];
    assign pix.pix_valid_out = v2;
endmodule

// File: doc/drawcon_multi.md
Name: drawcon_multi

Overview:
- Pipelined, parametrised pixel-colour and collision controller for the block-and-wall game.
- Supports NUM_WALLS independent walls, each with an enable and its own gap.
- Snapshots game-object positions once per frame and keeps a sticky lose flag, a pass score and a flashing lose screen.
- Sits between the game-logic/position blocks and the VGA timing/output stage.

Parameters:
- NUM_WALLS, 4, number of wall channels.
- COORD_W, 11, coordinate width.
- COLOR_W, 4, bits per colour channel.
- BLK_SIZE, 32, block edge length in pixels.
- WALL_W, 10, wall thickness in pixels.
- FIELD_X0/FIELD_X1, 9/1429, exclusive horizontal playfield bounds.
- FIELD_Y0/FIELD_Y1, 9/889, exclusive vertical playfield bounds.
- FLASH_BIT, 4, frame-counter bit that drives the lose flash.
- SCORE_W, 8, score width.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame
- restart  in  1  one-cycle pulse; clears lose and score
- sw  in  3*COLOR_W  background colour {b,g,r}
- blkpos_x, blkpos_y  in  COORD_W  block top-left position
- wall_x, gap_y, gap_size  in  NUM_WALLS*COORD_W  flattened per-wall data; wall i at slice [i*COORD_W +: COORD_W]
- wall_en  in  NUM_WALLS  per-wall enable
- draw_x, draw_y  in  COORD_W  current pixel coordinate
- pix_valid_in  in  1  pixel coordinate is valid
- r, g, b  out  COLOR_W  pixel colour (registered)
- pix_valid_out  out  1  pix_valid_in delayed by 2 cycles
- lose  out  1  sticky collision flag
- hit_wall  out  NUM_WALLS  walls colliding at the last frame_start evaluation
- score  out  SCORE_W  number of walls passed, saturating

Behaviour:
- Reset (async, rst_n=0): all outputs, snapshots, pipeline registers, frame counter and pass flags go to 0.
- Snapshot: on frame_start, register blkpos_*, wall_x, gap_y, gap_size and wall_en. Pixel rendering and collision use only snapshot values, so there is no mid-frame tearing. A pixel presented in the same cycle as frame_start still uses the old snapshot.
- Arithmetic: all comparisons are unsigned, done in COORD_W+2 bits. No subtraction is used, so there is no wrap-around.
- Collision for wall i (enabled):
  - horizontal: blk_x + BLK_SIZE - 1 > wall_x, and blk_x < wall_x + WALL_W + 1;
  - vertical: blk_y < gap_y, or blk_y + BLK_SIZE > gap_y + gap_size.
- Collision update: hit_wall is evaluated in the cycle after frame_start, from the new snapshot. lose is set in that same cycle if any hit_wall bit is 1. lose stays set until restart or reset.
- Pass tracking, per wall, evaluated in the cycle after frame_start:
  - pass condition: blk_x > wall_x + WALL_W, wall enabled, pass flag clear, lose clear;
  - on pass: set the pass flag and score += 1, saturating at all-ones;
  - the flag clears when blk_x + BLK_SIZE <= wall_x (wall recycled) or the wall is disabled;
  - several walls passing in the same frame add their count in one update, still saturating.
- restart: clears lose, score, hit_wall and pass flags next cycle. If restart coincides with a collision update, restart wins.
- Frame counter: 8-bit, increments on each frame_start, wraps.
- Pixel pipeline:
  - Stage 1 registers region hits: inside-field, on-block, on any enabled wall (outside the gap, inside the field).
  - Stage 2 registers the colour, using this priority:
    1. lose=1 and frame_cnt[FLASH_BIT]=0: red (all-ones,0,0) for every pixel;
    2. outside field: white;
    3. on block: (13,7,8) for r,g,b;
    4. on wall: red;
    5. otherwise: sw.
  - Block-box bounds are exclusive: draw_x > blk_x and draw_x < blk_x + BLK_SIZE, same in y.
  - Wall-box bounds are exclusive: draw_x > wall_x and draw_x < wall_x + WALL_W, same in y.
  - Latency is exactly 2 cycles, with no stalls.
  - When pix_valid_in=0 the output colour is 0.

Decomposition:
- Package drawcon_pkg holds:
  - colour constants: COL_WHITE, COL_RED, COL_BLOCK;
  - a function that slices one wall's field out of a flattened bus.
- Sub-module drawcon_wall_unit, one per wall (generate loop), provides:
  - snapshot-based pixel hit;
  - collision;
  - pass flag and pass pulse.
- The top level provides the OR/sum reduction, lose/score registers, frame counter and colour pipeline.

Test Plan:
- Reset: rst_n low mid-frame -> r,g,b, lose, score, pix_valid_out all 0 immediately. After release, pixel (100,100) with sw=0x123 -> r=3,g=2,b=1 two cycles later.
- Priority: blk=(100,100), wall0 x=110, gap_y=0, gap_size=0, snapshot taken, no collision expected check disabled via wall_en=0 then enabled. Pixel (112,300) -> red. Pixel (115,115) -> block colour (13,7,8).
- Collision: wall0 x=120, gap_y=300, gap_size=100, blk=(100,200), frame_start -> hit_wall=0001, lose=1 one cycle later. Frames with frame_cnt[4]=0 are full red; lose stays 1 after the block moves into the gap.
- Gap pass: blk=(100,320), same wall -> no collision. Then blk_x=131 -> score=1 after the next frame_start, and it does not re-increment on later frames. Wall_x moved to 1400 -> flag clears; the next pass gives score=2.
- Saturation/simultaneity: score=255 with 2 walls passing together -> stays 255. restart in the same cycle as a colliding frame_start evaluation -> lose=0, score=0.
- Boundaries: pixel x=9 -> white; x=10 -> background; x=1429 -> white. blk_x=wall_x+WALL_W exactly -> collision. blk_x=wall_x+WALL_W+1 -> no collision (pass). wall_x=0 with blk_x=0 -> collision with no underflow.
